// File: rtl/usb_line_state_detector.sv
// usb_line_state_detector
//   Host-side USB root-port line monitor. Brings the raw D+/D- pins into the clk domain,
//   debounces device attach and detach, classifies the device as low or full speed, and
//   flags resume signalling (K state) while the port is suspended.
//
// Ports
//   clk               system clock
//   rst               synchronous, active-high reset
//   lineStateIn       raw asynchronous {D+, D-} levels
//   suspendIn         port suspended; enables resume detection
//   connectStateOut   00 disconnected, 01 low speed, 10 full speed
//   resumeDetectedOut high while a qualified resume K is present
//   lineStateOut      synchronised line state for the downstream receiver
module usb_line_state_detector #(
   parameter int unsigned CONNECT_CYCLES    = 4800,
   parameter int unsigned DISCONNECT_CYCLES = 120,
   parameter int unsigned RESUME_CYCLES     = 48,
   parameter int unsigned CNT_W             = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] lineStateIn,
   input  logic       suspendIn,
   output logic [1:0] connectStateOut,
   output logic       resumeDetectedOut,
   output logic [1:0] lineStateOut
);

   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ConnLast = CNT_W'(CONNECT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DiscLast = CNT_W'(DISCONNECT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ResLim   = CNT_W'(RESUME_CYCLES);
   // kcnt + 1 >= RESUME_CYCLES rewritten as kcnt >= RESUME_CYCLES - 1 to avoid overflow.
   localparam logic [CNT_W-1:0] ResPrev  = CNT_W'(RESUME_CYCLES - 1);

   typedef enum logic [1:0] {StDisc, StDeb, StConn, StSe0W} state_e;

   state_e           state_q, state_d;
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] kcnt_q, kcnt_d;
   logic [1:0]       cand_q, cand_d;
   logic [1:0]       speed_q, speed_d;
   logic [1:0]       conn_q, conn_d;
   logic             resume_q, resume_d;

   logic [1:0]       line_sync;
   logic [1:0]       k_sym;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StDisc;
         sync1_q  <= 2'b00;
         sync2_q  <= 2'b00;
         cnt_q    <= '0;
         kcnt_q   <= '0;
         cand_q   <= 2'b00;
         speed_q  <= 2'b00;
         conn_q   <= 2'b00;
         resume_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         cnt_q    <= cnt_d;
         kcnt_q   <= kcnt_d;
         cand_q   <= cand_d;
         speed_q  <= speed_d;
         conn_q   <= conn_d;
         resume_q <= resume_d;
      end
   end

   // Next-state logic
   always_comb begin
      sync1_d   = lineStateIn;
      sync2_d   = sync1_q;
      line_sync = sync2_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      kcnt_d    = kcnt_q;
      cand_d    = cand_q;
      speed_d   = speed_q;
      conn_d    = conn_q;
      resume_d  = resume_q;

      // K is the idle level of the opposite speed: FS idles at 10 so K is 01, LS the reverse.
      case (speed_q)
         2'b10:   k_sym = 2'b01;
         2'b01:   k_sym = 2'b10;
         default: k_sym = 2'b00;
      endcase

      case (state_q)
         StDisc: begin
            if (line_sync == 2'b01 || line_sync == 2'b10) begin
               cand_d  = line_sync;
               cnt_d   = CntOne;
               state_d = StDeb;
            end
         end

         StDeb: begin
            if (line_sync != cand_q) begin
               cnt_d   = '0;
               state_d = StDisc;
            end else if (cnt_q == ConnLast) begin
               state_d = StConn;
               speed_d = cand_q;
               conn_d  = cand_q;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end

         StConn: begin
            if (line_sync == 2'b00) begin
               cnt_d   = CntOne;
               state_d = StSe0W;
            end
            // SE0 is never a K, so an SE0 arriving here also clears resume.
            if (suspendIn && line_sync == k_sym) begin
               if (kcnt_q != ResLim) begin
                  kcnt_d = kcnt_q + CntOne;
               end
               if (kcnt_q >= ResPrev) begin
                  resume_d = 1'b1;
               end
            end else begin
               kcnt_d   = '0;
               resume_d = 1'b0;
            end
         end

         StSe0W: begin
            resume_d = 1'b0;
            kcnt_d   = '0;
            if (line_sync != 2'b00) begin
               // Short SE0 (EOP, bus reset glitch) keeps the connection.
               cnt_d   = '0;
               state_d = StConn;
            end else if (cnt_q == DiscLast) begin
               state_d = StDisc;
               conn_d  = 2'b00;
               speed_d = 2'b00;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end

         default: begin
            state_d = StDisc;
         end
      endcase
   end

   // Outputs are all registered
   always_comb begin
      connectStateOut   = conn_q;
      resumeDetectedOut = resume_q;
      lineStateOut      = sync2_q;
   end

endmodule

// File: tb/tb_usb_line_state_detector.sv
module tb_usb_line_state_detector;

   logic       clk;
   logic       rst;
   logic [1:0] lineStateIn;
   logic       suspendIn;
   logic [1:0] connectStateOut;
   logic       resumeDetectedOut;
   logic [1:0] lineStateOut;

   int n_cmp;
   int n_err;

   usb_line_state_detector #(
      .CONNECT_CYCLES   (8),
      .DISCONNECT_CYCLES(4),
      .RESUME_CYCLES    (3),
      .CNT_W            (16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .lineStateIn      (lineStateIn),
      .suspendIn        (suspendIn),
      .connectStateOut  (connectStateOut),
      .resumeDetectedOut(resumeDetectedOut),
      .lineStateOut     (lineStateOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record per clock edge: inputs applied before the edge, outputs expected after it.
   typedef struct {
      logic       rst;
      logic [1:0] line;
      logic       sus;
      logic [1:0] conn;
      logic       res;
      logic [1:0] ls;
   } vec_t;

   vec_t tbl[$];

   function automatic void v(input logic r, input logic [1:0] l, input logic s,
                             input logic [1:0] c, input logic rs, input logic [1:0] lse,
                             input int rep);
      vec_t e;
      e.rst  = r;
      e.line = l;
      e.sus  = s;
      e.conn = c;
      e.res  = rs;
      e.ls   = lse;
      for (int i = 0; i < rep; i++) tbl.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %b, required %b (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] l, input logic s);
      @(negedge clk);
      rst         = r;
      lineStateIn = l;
      suspendIn   = s;
      @(posedge clk);
      #1;
   endtask

   task automatic fs_attach_vectors();
      v(0, 2'b10, 0, 2'b00, 0, 2'b00, 1);
      v(0, 2'b10, 0, 2'b00, 0, 2'b10, 8);
      v(0, 2'b10, 0, 2'b10, 0, 2'b10, 1);
      v(0, 2'b10, 0, 2'b10, 0, 2'b10, 2);
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      lineStateIn = 2'b00;
      suspendIn   = 1'b0;

      // Reset
      v(1, 2'b00, 0, 2'b00, 0, 2'b00, 2);
      // Full-speed attach: connect on the 10th edge after the pin change
      fs_attach_vectors();
      // EOP tolerance: three SE0 samples keep the connection
      v(0, 2'b00, 0, 2'b10, 0, 2'b10, 1);
      v(0, 2'b00, 0, 2'b10, 0, 2'b00, 2);
      v(0, 2'b10, 0, 2'b10, 0, 2'b00, 1);
      v(0, 2'b10, 0, 2'b10, 0, 2'b10, 3);
      // Detach: disconnect on the edge of the 4th SE0 sample
      v(0, 2'b00, 0, 2'b10, 0, 2'b10, 1);
      v(0, 2'b00, 0, 2'b10, 0, 2'b00, 4);
      v(0, 2'b00, 0, 2'b00, 0, 2'b00, 2);
      // Bouncy low-speed attach
      v(0, 2'b01, 0, 2'b00, 0, 2'b00, 1);
      v(0, 2'b01, 0, 2'b00, 0, 2'b01, 4);
      v(0, 2'b00, 0, 2'b00, 0, 2'b01, 1);
      v(0, 2'b01, 0, 2'b00, 0, 2'b00, 1);
      v(0, 2'b01, 0, 2'b00, 0, 2'b01, 8);
      v(0, 2'b01, 0, 2'b01, 0, 2'b01, 2);
      // Low-speed resume: K is 10
      v(0, 2'b10, 1, 2'b01, 0, 2'b01, 1);
      v(0, 2'b10, 1, 2'b01, 0, 2'b10, 3);
      v(0, 2'b01, 1, 2'b01, 1, 2'b10, 1);
      v(0, 2'b01, 1, 2'b01, 1, 2'b01, 1);
      v(0, 2'b01, 1, 2'b01, 0, 2'b01, 3);
      // Low-speed detach
      v(0, 2'b00, 0, 2'b01, 0, 2'b01, 1);
      v(0, 2'b00, 0, 2'b01, 0, 2'b00, 4);
      v(0, 2'b00, 0, 2'b00, 0, 2'b00, 1);
      // Full-speed re-attach
      fs_attach_vectors();
      // Full-speed resume: K is 01, drops 3 edges after line returns to J
      v(0, 2'b01, 1, 2'b10, 0, 2'b10, 1);
      v(0, 2'b01, 1, 2'b10, 0, 2'b01, 3);
      v(0, 2'b01, 1, 2'b10, 1, 2'b01, 1);
      v(0, 2'b10, 1, 2'b10, 1, 2'b01, 1);
      v(0, 2'b10, 1, 2'b10, 1, 2'b10, 1);
      v(0, 2'b10, 1, 2'b10, 0, 2'b10, 2);
      // Same K without suspend: no resume
      v(0, 2'b01, 0, 2'b10, 0, 2'b10, 1);
      v(0, 2'b01, 0, 2'b10, 0, 2'b01, 4);
      v(0, 2'b10, 0, 2'b10, 0, 2'b01, 1);
      v(0, 2'b10, 0, 2'b10, 0, 2'b10, 2);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].line, tbl[i].sus);
         chk($sformatf("vec%0d conn", i), connectStateOut, tbl[i].conn);
         chk($sformatf("vec%0d resume", i), {1'b0, resumeDetectedOut}, {1'b0, tbl[i].res});
         chk($sformatf("vec%0d line", i), lineStateOut, tbl[i].ls);
      end

      // suspendIn falling during K clears resume on the next edge
      for (int k = 1; k <= 5; k++) begin
         step(0, 2'b01, 1);
         if (k == 4) chk("susp_fall pre", {1'b0, resumeDetectedOut}, 2'b00);
      end
      chk("susp_fall set", {1'b0, resumeDetectedOut}, 2'b01);
      step(0, 2'b01, 0);
      chk("susp_fall clr", {1'b0, resumeDetectedOut}, 2'b00);
      for (int k = 0; k < 3; k++) step(0, 2'b10, 0);
      chk("susp_fall conn", connectStateOut, 2'b10);

      // SE0 on the cycle a resume count would complete: SE0 wins, connection kept
      step(0, 2'b01, 1);
      step(0, 2'b01, 1);
      step(0, 2'b00, 1);
      step(0, 2'b10, 1);
      chk("se0_win e4", {1'b0, resumeDetectedOut}, 2'b00);
      step(0, 2'b10, 1);
      chk("se0_win e5", {1'b0, resumeDetectedOut}, 2'b00);
      step(0, 2'b10, 1);
      chk("se0_win conn", connectStateOut, 2'b10);
      step(0, 2'b10, 1);
      chk("se0_win res", {1'b0, resumeDetectedOut}, 2'b00);
      step(0, 2'b10, 0);
      step(0, 2'b10, 0);

      // Reset mid-operation with resume active, then a full re-attach
      for (int k = 0; k < 5; k++) step(0, 2'b01, 1);
      chk("rst_mid pre res", {1'b0, resumeDetectedOut}, 2'b01);
      step(1, 2'b10, 1);
      chk("rst_mid conn", connectStateOut, 2'b00);
      chk("rst_mid res", {1'b0, resumeDetectedOut}, 2'b00);
      chk("rst_mid line", lineStateOut, 2'b00);
      for (int k = 1; k <= 10; k++) begin
         step(0, 2'b10, 0);
         if (k == 1) chk("reatt line1", lineStateOut, 2'b00);
         if (k == 2) chk("reatt line2", lineStateOut, 2'b10);
         if (k == 9) chk("reatt conn9", connectStateOut, 2'b00);
         if (k == 10) chk("reatt conn10", connectStateOut, 2'b10);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
